// File: rtl/fifo_watermark.sv
// Synchronous FIFO with run-time almost-full/almost-empty thresholds,
// a clearable peak-occupancy register and sticky overflow/underflow flags.
module fifo_watermark #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                testmode_i,
    input  logic [ADDR_DEPTH:0] alm_full_th_i,
    input  logic [ADDR_DEPTH:0] alm_empty_th_i,
    input  dtype                data_i,
    input  logic                push_i,
    input  logic                pop_i,
    output dtype                data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                alm_full_o,
    output logic                alm_empty_o,
    output logic [ADDR_DEPTH:0] usage_o,
    output logic [ADDR_DEPTH:0] peak_o,
    input  logic                peak_clr_i,
    output logic                overflow_o,
    output logic                underflow_o,
    input  logic                err_clr_i
);

    localparam logic [ADDR_DEPTH:0]   DEPTH_CNT = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR  = ADDR_DEPTH'(DEPTH - 1);

    if (DEPTH == 0) begin : g_depth_check
        $fatal(1, "fifo_watermark: DEPTH must be at least 1");
    end

    dtype                  mem_reg [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_DEPTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_DEPTH:0]   usage_reg, usage_next;
    logic [ADDR_DEPTH:0]   peak_reg, peak_next;
    logic                  full_reg, full_next;
    logic                  empty_reg, empty_next;
    logic                  ovf_reg, ovf_next;
    logic                  udf_reg, udf_next;
    logic                  bypass, push_ok, pop_ok, ovf_evt, udf_evt;

    // Clock-gating bypass only; it has no functional role here.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    always_comb begin
        bypass  = FALL_THROUGH && empty_reg && push_i && pop_i && !flush_i;
        push_ok = push_i && !full_reg && !flush_i && !bypass;
        pop_ok  = pop_i && !empty_reg && !flush_i;
        ovf_evt = push_i && full_reg && !flush_i;
        udf_evt = pop_i && empty_reg && !flush_i && !bypass;
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        usage_next  = usage_reg;
        if (flush_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            usage_next  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                usage_next = usage_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                usage_next = usage_reg - 1'b1;
            end
        end
        full_next  = (usage_next == DEPTH_CNT);
        empty_next = (usage_next == '0);
        // Peak is reloaded from the incoming level so a clear never loses a live maximum.
        if (peak_clr_i) begin
            peak_next = usage_next;
        end else begin
            peak_next = (usage_next > peak_reg) ? usage_next : peak_reg;
        end
        ovf_next = ovf_evt || (ovf_reg && !err_clr_i);
        udf_next = udf_evt || (udf_reg && !err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            usage_reg  <= '0;
            peak_reg   <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            usage_reg  <= usage_next;
            peak_reg   <= peak_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            ovf_reg    <= ovf_next;
            udf_reg    <= udf_next;
        end
    end

    // Storage carries no reset: contents are meaningless until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end

    always_comb begin
        data_o = mem_reg[rd_ptr_reg];
        if (FALL_THROUGH && empty_reg && push_i) begin
            data_o = data_i;
        end
    end

    assign full_o      = full_reg;
    assign empty_o     = empty_reg;
    assign usage_o     = usage_reg;
    assign peak_o      = peak_reg;
    assign overflow_o  = ovf_reg;
    assign underflow_o = udf_reg;
    assign alm_full_o  = (usage_reg >= alm_full_th_i);
    assign alm_empty_o = (usage_reg <= alm_empty_th_i);

endmodule

// File: tb/tb_fifo_watermark.sv
// Bench for fifo_watermark: a DEPTH=5 plain instance and a DEPTH=8
// fall-through instance, each with a data scoreboard queue.
module tb_fifo_watermark;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DEPTH=5, FALL_THROUGH=0
    logic        push5, pop5, flush5, pclr5, eclr5;
    logic [15:0] data5, dout5;
    logic [3:0]  afth5, aeth5, usage5, peak5;
    logic        full5, empty5, af5, ae5, ovf5, udf5;
    logic [15:0] q5 [$];

    // DEPTH=8, FALL_THROUGH=1
    logic        push8, pop8, flush8, pclr8, eclr8;
    logic [15:0] data8, dout8;
    logic [3:0]  afth8, aeth8, usage8, peak8;
    logic        full8, empty8, af8, ae8, ovf8, udf8;
    logic [15:0] q8 [$];

    logic [15:0] exp_d;

    fifo_watermark #(.FALL_THROUGH(1'b0), .DATA_WIDTH(16), .DEPTH(5)) u_d5 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush5), .testmode_i(1'b0),
        .alm_full_th_i(afth5), .alm_empty_th_i(aeth5), .data_i(data5),
        .push_i(push5), .pop_i(pop5), .data_o(dout5), .full_o(full5),
        .empty_o(empty5), .alm_full_o(af5), .alm_empty_o(ae5), .usage_o(usage5),
        .peak_o(peak5), .peak_clr_i(pclr5), .overflow_o(ovf5),
        .underflow_o(udf5), .err_clr_i(eclr5)
    );

    fifo_watermark #(.FALL_THROUGH(1'b1), .DATA_WIDTH(16), .DEPTH(8)) u_d8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush8), .testmode_i(1'b0),
        .alm_full_th_i(afth8), .alm_empty_th_i(aeth8), .data_i(data8),
        .push_i(push8), .pop_i(pop8), .data_o(dout8), .full_o(full8),
        .empty_o(empty8), .alm_full_o(af8), .alm_empty_o(ae8), .usage_o(usage8),
        .peak_o(peak8), .peak_clr_i(pclr8), .overflow_o(ovf8),
        .underflow_o(udf8), .err_clr_i(eclr8)
    );

    task automatic drive5(input logic p, input logic po, input logic [15:0] d);
        @(negedge clk);
        push5 = p; pop5 = po; data5 = d;
    endtask

    task automatic drive8(input logic p, input logic po, input logic [15:0] d);
        @(negedge clk);
        push8 = p; pop8 = po; data8 = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        push5 = 0; pop5 = 0; flush5 = 0; pclr5 = 0; eclr5 = 0;
        push8 = 0; pop8 = 0; flush8 = 0; pclr8 = 0; eclr8 = 0;
    endtask

    task automatic pop_check5(input string tag);
        drive5(1'b0, 1'b1, 16'h0);
        #1;
        exp_d = q5.pop_front();
        $display("%s: d5 pop data=%h expected=%h", tag, dout5, exp_d);
        n_cmp++; if (dout5 !== exp_d) begin n_err++; $display("FAIL %s_data: got %h want %h", tag, dout5, exp_d); end
        tick;
    endtask

    task automatic pop_check8(input string tag);
        drive8(1'b0, 1'b1, 16'h0);
        #1;
        exp_d = q8.pop_front();
        $display("%s: d8 pop data=%h expected=%h", tag, dout8, exp_d);
        n_cmp++; if (dout8 !== exp_d) begin n_err++; $display("FAIL %s_data: got %h want %h", tag, dout8, exp_d); end
        tick;
    endtask

    task automatic test_reset;
        n_cmp++; if (usage5 !== 4'd0) begin n_err++; $display("FAIL rst_usage5: got %0d want 0", usage5); end
        n_cmp++; if (peak5 !== 4'd0) begin n_err++; $display("FAIL rst_peak5: got %0d want 0", peak5); end
        n_cmp++; if ({empty5, full5, ovf5, udf5} !== 4'b1000) begin n_err++; $display("FAIL rst_flags5: got %b want 1000", {empty5, full5, ovf5, udf5}); end
        n_cmp++; if ({af5, ae5} !== {afth5 == 4'd0, 1'b1}) begin n_err++; $display("FAIL rst_alm5: got %b want %b", {af5, ae5}, {afth5 == 4'd0, 1'b1}); end
        n_cmp++; if ({usage8, peak8} !== 8'h00) begin n_err++; $display("FAIL rst_cnt8: got %h want 00", {usage8, peak8}); end
        n_cmp++; if ({empty8, full8, ovf8, udf8, ae8} !== 5'b10001) begin n_err++; $display("FAIL rst_flags8: got %b want 10001", {empty8, full8, ovf8, udf8, ae8}); end
        $display("reset: checked both instances");
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 5; i++) begin
            drive5(1'b1, 1'b0, 16'hA0 + 16'(i));
            q5.push_back(16'hA0 + 16'(i));
            tick;
            $display("ovf: push %h usage=%0d", 16'hA0 + 16'(i), usage5);
            n_cmp++; if (usage5 !== 4'(i + 1)) begin n_err++; $display("FAIL fill_usage: got %0d want %0d", usage5, i + 1); end
            n_cmp++; if (full5 !== (i == 4)) begin n_err++; $display("FAIL fill_full: got %b want %b", full5, i == 4); end
        end
        n_cmp++; if (ovf5 !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf5); end
        drive5(1'b1, 1'b0, 16'hF0);
        tick;
        n_cmp++; if ({full5, usage5, ovf5} !== {1'b1, 4'd5, 1'b1}) begin n_err++; $display("FAIL ovf_push_full: got %b want 1_0101_1", {full5, usage5, ovf5}); end
        for (int i = 0; i < 5; i++) pop_check5("drain");
        n_cmp++; if ({empty5, usage5, udf5} !== {1'b1, 4'd0, 1'b0}) begin n_err++; $display("FAIL drain_state: got %b want 1_0000_0", {empty5, usage5, udf5}); end
        drive5(1'b0, 1'b1, 16'h0);
        tick;
        n_cmp++; if ({udf5, usage5, empty5} !== {1'b1, 4'd0, 1'b1}) begin n_err++; $display("FAIL udf_pop_empty: got %b want 1_0000_1", {udf5, usage5, empty5}); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 2; i++) begin
            drive5(1'b1, 1'b0, 16'hB0 + 16'(i));
            q5.push_back(16'hB0 + 16'(i));
            tick;
        end
        for (int i = 2; i < 9; i++) begin
            drive5(1'b1, 1'b1, 16'hB0 + 16'(i));
            #1;
            exp_d = q5.pop_front();
            q5.push_back(16'hB0 + 16'(i));
            $display("b2b: d5 push %h pop data=%h expected=%h", 16'hB0 + 16'(i), dout5, exp_d);
            n_cmp++; if (dout5 !== exp_d) begin n_err++; $display("FAIL b2b_data: got %h want %h", dout5, exp_d); end
            tick;
            n_cmp++; if (usage5 !== 4'd2) begin n_err++; $display("FAIL b2b_usage: got %0d want 2", usage5); end
        end
        pop_check5("b2b_tail");
        pop_check5("b2b_tail");
        n_cmp++; if (empty5 !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty5); end
    endtask

    task automatic test_err_clr;
        @(negedge clk); eclr5 = 1;
        tick;
        n_cmp++; if ({ovf5, udf5} !== 2'b00) begin n_err++; $display("FAIL errclr: got %b want 00", {ovf5, udf5}); end
        for (int i = 0; i < 5; i++) begin
            drive5(1'b1, 1'b0, 16'hC0 + 16'(i));
            q5.push_back(16'hC0 + 16'(i));
            tick;
        end
        drive5(1'b1, 1'b0, 16'hCF); eclr5 = 1;
        tick;
        $display("errclr: push on full with clear, ovf=%b", ovf5);
        n_cmp++; if ({ovf5, full5} !== 2'b11) begin n_err++; $display("FAIL errclr_set_wins: got %b want 11", {ovf5, full5}); end
        // push+pop on full: pop taken, push dropped
        drive5(1'b1, 1'b1, 16'hDD);
        #1;
        exp_d = q5.pop_front();
        n_cmp++; if (dout5 !== exp_d) begin n_err++; $display("FAIL full_pp_data: got %h want %h", dout5, exp_d); end
        tick;
        n_cmp++; if ({usage5, full5, ovf5} !== {4'd4, 1'b0, 1'b1}) begin n_err++; $display("FAIL full_pp_state: got %b want 0100_0_1", {usage5, full5, ovf5}); end
    endtask

    task automatic test_fall_through;
        drive8(1'b1, 1'b1, 16'hCAFE);
        #1;
        $display("ft: bypass data=%h", dout8);
        n_cmp++; if (dout8 !== 16'hCAFE) begin n_err++; $display("FAIL ft_bypass_data: got %h want cafe", dout8); end
        tick;
        n_cmp++; if ({usage8, empty8, ovf8, udf8} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL ft_bypass_state: got %b want 0000_1_0_0", {usage8, empty8, ovf8, udf8}); end
        drive8(1'b1, 1'b0, 16'hBEEF);
        #1;
        n_cmp++; if (dout8 !== 16'hBEEF) begin n_err++; $display("FAIL ft_push_data: got %h want beef", dout8); end
        q8.push_back(16'hBEEF);
        tick;
        n_cmp++; if ({usage8, empty8} !== {4'd1, 1'b0}) begin n_err++; $display("FAIL ft_push_state: got %b want 0001_0", {usage8, empty8}); end
        pop_check8("ft_pop");
    endtask

    task automatic test_thresholds;
        for (int u = 0; u <= 8; u++) begin
            $display("thr: usage=%0d af=%b ae=%b", usage8, af8, ae8);
            n_cmp++; if (usage8 !== 4'(u)) begin n_err++; $display("FAIL thr_usage: got %0d want %0d", usage8, u); end
            n_cmp++; if ({af8, ae8} !== {u >= 6, u <= 2}) begin n_err++; $display("FAIL thr_alm: got %b want %b at %0d", {af8, ae8}, {u >= 6, u <= 2}, u); end
            if (u == 4) begin
                @(negedge clk); afth8 = 4'd3;
                #1;
                n_cmp++; if (af8 !== 1'b1) begin n_err++; $display("FAIL thr_change_af: got %b want 1", af8); end
                afth8 = 4'd6;
                #1;
            end
            if (u < 8) begin
                drive8(1'b1, 1'b0, 16'h80 + 16'(u));
                q8.push_back(16'h80 + 16'(u));
                tick;
            end
        end
        n_cmp++; if ({full8, peak8} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL thr_full: got %b want 1_1000", {full8, peak8}); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) pop_check8("pre_flush");
        drive8(1'b1, 1'b0, 16'h1234); flush8 = 1;
        tick;
        q8.delete();
        $display("flush: usage=%0d empty=%b", usage8, empty8);
        n_cmp++; if ({usage8, empty8, ovf8} !== {4'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL flush_state: got %b want 0000_1_0", {usage8, empty8, ovf8}); end
        n_cmp++; if (peak8 !== 4'd8) begin n_err++; $display("FAIL flush_peak: got %0d want 8", peak8); end
    endtask

    task automatic test_peak;
        @(negedge clk); pclr8 = 1;
        tick;
        n_cmp++; if (peak8 !== 4'd0) begin n_err++; $display("FAIL peak_clr0: got %0d want 0", peak8); end
        for (int i = 0; i < 7; i++) begin
            drive8(1'b1, 1'b0, 16'hE0 + 16'(i));
            q8.push_back(16'hE0 + 16'(i));
            tick;
        end
        for (int i = 0; i < 4; i++) pop_check8("peak_pop");
        n_cmp++; if ({peak8, usage8} !== {4'd7, 4'd3}) begin n_err++; $display("FAIL peak_hold: got %h want 73", {peak8, usage8}); end
        @(negedge clk); pclr8 = 1;
        tick;
        $display("peak: after clear peak=%0d", peak8);
        n_cmp++; if (peak8 !== 4'd3) begin n_err++; $display("FAIL peak_clr: got %0d want 3", peak8); end
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        $display("async reset: usage8=%0d usage5=%0d", usage8, usage5);
        n_cmp++; if ({usage8, peak8} !== 8'h00) begin n_err++; $display("FAIL arst_cnt8: got %h want 00", {usage8, peak8}); end
        n_cmp++; if ({empty8, full8, ovf8, udf8, ae8, af8} !== {5'b10001, afth8 == 4'd0}) begin n_err++; $display("FAIL arst_flags8: got %b", {empty8, full8, ovf8, udf8, ae8, af8}); end
        n_cmp++; if ({usage5, empty5, full5, ovf5, udf5} !== {4'd0, 4'b1000}) begin n_err++; $display("FAIL arst_d5: got %b want 0000_1000", {usage5, empty5, full5, ovf5, udf5}); end
        @(negedge clk); rst_n = 1;
        q5.delete(); q8.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        push5 = 0; pop5 = 0; flush5 = 0; pclr5 = 0; eclr5 = 0; data5 = '0;
        push8 = 0; pop8 = 0; flush8 = 0; pclr8 = 0; eclr8 = 0; data8 = '0;
        afth5 = 4'd4; aeth5 = 4'd1; afth8 = 4'd6; aeth8 = 4'd2;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        #1;
        test_reset;
        test_overflow;
        test_back_to_back;
        test_err_clr;
        test_fall_through;
        test_thresholds;
        test_flush;
        test_peak;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
